// File: rtl/fft_mag_buffer.sv
// fft_mag_buffer: converts FFT output bins (signed re/im) into scaled,
// saturated magnitude-squared values. It stores one frame in a bin RAM that
// the host reads while the frame is held.
// Optional peak detector: define FFT_MAG_PEAK_EN to build it; otherwise
// peak_bin/peak_mag are tied to zero.
module fft_mag_buffer #(
  parameter int FFT_LEN   = 512,
  parameter int DATA_W    = 24,
  parameter int MAG_SHIFT = 16
) (
  input  logic                       Bus2IP_Clk,
  input  logic                       Bus2IP_Reset,
  input  logic [2*DATA_W-1:0]        s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       rd_en,
  input  logic [$clog2(FFT_LEN)-1:0] rd_addr,
  output logic [31:0]                rd_data,
  input  logic                       frame_ack,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin,
  output logic [31:0]                peak_mag
);

  localparam int AW    = $clog2(FFT_LEN);
  localparam int SQ_W  = 2*DATA_W;
  localparam int SUM_W = SQ_W + 1;
  localparam int EXT_W = SUM_W + 32;
  localparam logic [AW-1:0] LAST_BIN = AW'(FFT_LEN - 1);

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   bin_cnt_q, bin_cnt_d;
  logic            err_q, err_d;
  logic            accept, last_bin, ack_take, wr_en;

  // pipeline stage registers
  logic                s1_v_q, s1_last_q;
  logic [AW-1:0]       s1_bin_q;
  logic [DATA_W-1:0]   s1_re_q, s1_im_q;
  logic                s2_v_q, s2_last_q;
  logic [AW-1:0]       s2_bin_q;
  logic [SQ_W-1:0]     s2_sqre_q, s2_sqim_q;
  logic                s3_v_q, s3_last_q;
  logic [AW-1:0]       s3_bin_q;
  logic [31:0]         s3_mag_q;

  logic [DATA_W-1:0]   abs_re_d, abs_im_d;
  logic [SUM_W-1:0]    sum_d;
  logic [EXT_W-1:0]    ext_d;
  logic [31:0]         mag_d;

  logic [31:0]         mem [FFT_LEN];
  logic [31:0]         rd_data_q;

  function automatic logic [DATA_W-1:0] abs_f(input logic [DATA_W-1:0] x);
    // the most negative input maps to 2^(DATA_W-1), which still fits unsigned
    return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

  assign accept   = s_axis_tvalid & (state_q == FILL) & ~Bus2IP_Reset;
  assign last_bin = (bin_cnt_q == LAST_BIN);
  assign ack_take = (state_q == HOLD) & frame_ack;
  // a write still in flight when reset asserts must not land in the RAM
  assign wr_en    = s3_v_q & ~Bus2IP_Reset;

  // frame control state, bin counter and error flag registers
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q   <= FILL;
      bin_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      err_q     <= err_d;
    end
  end

  // next-state logic and handshake/status outputs
  always_comb begin
    state_d       = state_q;
    bin_cnt_d     = bin_cnt_q;
    err_d         = err_q;
    s_axis_tready = 1'b0;
    frame_done    = 1'b0;
    case (state_q)
      FILL: begin
        s_axis_tready = ~Bus2IP_Reset;
        if (accept) begin
          bin_cnt_d = bin_cnt_q + AW'(1);
          if (s_axis_tlast || last_bin) begin
            state_d = DRAIN;
            err_d   = s_axis_tlast ^ last_bin;
          end
        end
      end
      DRAIN: begin
        if (wr_en && s3_last_q) state_d = HOLD;
      end
      HOLD: begin
        frame_done = 1'b1;
        if (frame_ack) begin
          state_d   = FILL;
          bin_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // magnitude datapath combinational pieces
  always_comb begin
    abs_re_d = abs_f(s_axis_tdata[DATA_W-1:0]);
    abs_im_d = abs_f(s_axis_tdata[2*DATA_W-1:DATA_W]);
    sum_d    = {1'b0, s2_sqre_q} + {1'b0, s2_sqim_q};
    ext_d    = {32'b0, sum_d} >> MAG_SHIFT;
    mag_d    = (|ext_d[EXT_W-1:32]) ? '1 : ext_d[31:0];
  end

  // pipeline valid flags, flushed by reset
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
    end
  end

  // pipeline data: abs, squares, scaled/saturated sum
  always_ff @(posedge Bus2IP_Clk) begin
    s1_re_q   <= abs_re_d;
    s1_im_q   <= abs_im_d;
    s1_bin_q  <= bin_cnt_q;
    s1_last_q <= s_axis_tlast | last_bin;
    s2_sqre_q <= SQ_W'(s1_re_q) * SQ_W'(s1_re_q);
    s2_sqim_q <= SQ_W'(s1_im_q) * SQ_W'(s1_im_q);
    s2_bin_q  <= s1_bin_q;
    s2_last_q <= s1_last_q;
    s3_mag_q  <= mag_d;
    s3_bin_q  <= s2_bin_q;
    s3_last_q <= s2_last_q;
  end

  // bin RAM write port (contents are not reset)
  always_ff @(posedge Bus2IP_Clk) begin
    if (wr_en) mem[s3_bin_q] <= s3_mag_q;
  end

  // registered read port; same-cycle write to the same bin returns old data
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset)  rd_data_q <= '0;
    else if (rd_en)    rd_data_q <= mem[rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign frame_err = err_q;

`ifdef FFT_MAG_PEAK_EN
  logic          pk_seen_q;
  logic [AW-1:0] pk_bin_q;
  logic [31:0]   pk_mag_q;

  // track strongest bin; strict compare keeps the lowest index on ties
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || ack_take) begin
      pk_seen_q <= 1'b0;
      pk_bin_q  <= '0;
      pk_mag_q  <= '0;
    end else if (wr_en && (!pk_seen_q || (s3_mag_q > pk_mag_q))) begin
      pk_seen_q <= 1'b1;
      pk_bin_q  <= s3_bin_q;
      pk_mag_q  <= s3_mag_q;
    end
  end

  assign peak_bin = pk_bin_q;
  assign peak_mag = pk_mag_q;
`else
  logic unused_ack;
  assign unused_ack = ack_take;
  assign peak_bin   = '0;
  assign peak_mag   = '0;
`endif

endmodule

// File: doc/fft_mag_buffer.md
# fft_mag_buffer

Downstream stage of the FFT core: consumes the FFT output AXI4-Stream (24-bit signed real/imag per bin), computes a scaled, saturated magnitude-squared per bin through a 3-stage pipeline, and stores one full frame in a single-port-write / registered-read bin RAM. A completed frame is held for the processor to read over the IPIF memory path. An optional peak detector reports the strongest bin. The FFT output is back-pressured while the held frame is unacknowledged.

## Interface
- FFT_LEN, 512: bins per frame; power of two, 8..1024; address width is log2(FFT_LEN)
- DATA_W, 24: signed width of each real/imag component
- MAG_SHIFT, 16: right shift applied to re²+im² before saturation to 32 bits
- Bus2IP_Clk  in  1  sole clock; all logic on rising edge
- Bus2IP_Reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  2*DATA_W  {imag[2*DATA_W-1:DATA_W], real[DATA_W-1:0]}, two's complement
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last bin of frame
- s_axis_tready  out  1  beat accepted when tvalid & tready
- rd_en  in  1  read strobe
- rd_addr  in  log2(FFT_LEN)  bin index to read
- rd_data  out  32  magnitude of rd_addr, valid one cycle after rd_en
- frame_ack  in  1  single-cycle pulse: host finished with held frame
- frame_done  out  1  held frame complete and readable
- frame_err  out  1  last frame had tlast early or missing
- peak_bin  out  log2(FFT_LEN)  index of largest magnitude in held frame
- peak_mag  out  32  magnitude at peak_bin

## Operation
- States: FILL (accepting), DRAIN (last beat accepted, pipeline emptying), HOLD (frame readable).
- FILL: s_axis_tready=1. Each accepted beat takes bin index from counter bin_cnt (0..FFT_LEN-1), then increments it.
- FILL→DRAIN when accepted beat has tlast=1 or bin_cnt=FFT_LEN-1; tready drops the next cycle.
- frame_err set on entry to DRAIN if (tlast=1 and bin_cnt≠FFT_LEN-1) or (tlast=0 and bin_cnt=FFT_LEN-1); early-tlast frame ends short, unwritten bins keep stale RAM contents.
- DRAIN→HOLD when the final beat is written to RAM; frame_done=1 in HOLD.
- HOLD→FILL on frame_ack: bin_cnt=0, frame_done=0, frame_err cleared, peak registers cleared. frame_ack outside HOLD is ignored.
- Pipeline: S1 abs of each component into DATA_W unsigned (−2^(DATA_W−1) → 2^(DATA_W−1), no overflow); S2 two 2*DATA_W squares; S3 sum (2*DATA_W+1 bits), shift right MAG_SHIFT, saturate to 0xFFFF_FFFF, write RAM[bin].
- Peak: at each S3 write, if mag > peak_mag (strictly), peak_mag←mag, peak_bin←bin; ties keep lowest index. First write of frame always loads.
- Reads allowed in any state; reads in FILL/DRAIN return mixed old/new frame data (not an error).
- Simultaneous rd_en and S3 write to same address: rd_data returns the old value (read-before-write).

## Timing
- Reset values: s_axis_tready=0 during reset, 1 first cycle after release (FILL); frame_done=0, frame_err=0, peak_bin=0, peak_mag=0, rd_data=0. RAM not reset.
- Beat accepted cycle t → RAM write at edge ending t+3; peak updated same edge.
- Final beat at cycle t → tready=0 from t+1, frame_done=1 from t+4.
- frame_ack at cycle a → frame_done=0 and tready=1 from a+1.
- rd_en at cycle r → rd_data valid at r+1, held until next rd_en.
- Reset mid-frame: pipeline flushed, partial frame discarded, state FILL, no RAM write after reset asserts.
- Throughput: one bin per cycle with tvalid held high.

## Configuration
- FFT_MAG_PEAK_EN defined: peak detector built as above.
- Undefined: no peak logic; peak_bin and peak_mag tied to 0.

## Test plan
- Reset, FFT_LEN=512, stream 512 beats real=i, imag=0, tlast on beat 511 → frame_done 4 cycles after beat 511, frame_err=0, RAM[i]=(i²)>>16, e.g. RAM[511]=3.
- Beat with real=imag=−2^23 → sum 2^47, >>16 = 0x8000_0000 stored; MAG_SHIFT=0 with same input → 0xFFFF_FFFF (saturated).
- tlast on beat 99 → frame_done, frame_err=1, bins 100..511 unchanged; tlast absent on beat 511 → frame ends, frame_err=1.
- Hold frame, keep tvalid high → tready=0, no RAM change; pulse frame_ack → tready=1 next cycle, next frame overwrites.
- Magnitudes 5 at bins 10 and 40, 3 elsewhere → peak_bin=10, peak_mag=5 (with FFT_MAG_PEAK_EN); without macro both 0.
- Assert Bus2IP_Reset on beat 200 → tready=0, frame_done=0; after release new 512-beat frame completes normally with frame_err=0.
